bf_tape: RTL and testbench



---
 rtl/bf_tape.sv | 172 +++++++++++++++++
 tb/tb_bf_tape.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_tape.sv
// Brainfuck data tape: cell memory, data pointer and cached current cell behind a valid/ready port.
// Optional: define BF_TAPE_WRAP_EN for a wrapping pointer; otherwise the pointer saturates and sets err.
module bf_tape #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] cell_out,
  output logic              cell_zero,
  output logic [ADDR_W-1:0] ptr_out,
  output logic              err
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FETCH} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_WRITE, OP_ADD, OP_CLEAR_ALL
  } op_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] cur;
  op_t               op;
  logic              accept;

  logic [DATA_W-1:0] cur_wr;
  logic              cell_we;
  logic [ADDR_W-1:0] ptr_mv;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
`ifndef BF_TAPE_WRAP_EN
  logic              oob;
`endif

  assign op     = op_t'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    cur_wr  = cur;
    cell_we = 1'b0;
    ptr_mv  = ptr;
`ifndef BF_TAPE_WRAP_EN
    oob     = 1'b0;
`endif
    if (accept) begin
      case (op)
        OP_INC:   begin cur_wr = cur + DATA_W'(1); cell_we = 1'b1; end
        OP_DEC:   begin cur_wr = cur - DATA_W'(1); cell_we = 1'b1; end
        OP_WRITE: begin cur_wr = cmd_data;         cell_we = 1'b1; end
        OP_ADD:   begin cur_wr = cur + cmd_data;   cell_we = 1'b1; end
        OP_RIGHT: begin
          if (ptr == LAST) begin
`ifdef BF_TAPE_WRAP_EN
            ptr_mv = '0;
`else
            oob    = 1'b1;
`endif
          end else begin
            ptr_mv = ptr + ADDR_W'(1);
          end
        end
        OP_LEFT: begin
          if (ptr == '0) begin
`ifdef BF_TAPE_WRAP_EN
            ptr_mv = LAST;
`else
            oob    = 1'b1;
`endif
          end else begin
            ptr_mv = ptr - ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Clear sweep and write-through share the single write port; they never overlap.
  always_comb begin
    mem_we = cell_we;
    mem_wa = ptr;
    mem_wd = cur_wr;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      cnt       <= '0;
      cur       <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cur <= '0;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_INC, OP_DEC, OP_WRITE, OP_ADD: cur <= cur_wr;
              OP_RIGHT, OP_LEFT: begin
                ptr       <= ptr_mv;
                state     <= S_FETCH;
                cmd_ready <= 1'b0;
              end
              OP_CLEAR_ALL: begin
                ptr       <= '0;
                cnt       <= '0;
                state     <= S_CLEAR;
                cmd_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_FETCH: begin
          cur       <= mem[ptr];
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_CLEAR;
          cnt       <= '0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef BF_TAPE_WRAP_EN
  assign err = 1'b0;
`else
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err_q <= 1'b0;
    else if (accept && oob) err_q <= 1'b1;
  end
  assign err = err_q;
`endif

  assign cell_out  = cur;
  assign cell_zero = (cur == '0);
  assign ptr_out   = ptr;

endmodule

// File: tb/tb_bf_tape.sv
// Self-checking bench for bf_tape: directed scenarios plus random commands against a tape-array model.
module tb_bf_tape;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int MOD    = 1 << DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DATA_W-1:0] cell_out;
  logic              cell_zero;
  logic [ADDR_W-1:0] ptr_out;
  logic              err;

  bf_tape #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cell_out(cell_out),
    .cell_zero(cell_zero), .ptr_out(ptr_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tape [DEPTH];
  int mptr;
  bit merr;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear_tape();
    for (int i = 0; i < DEPTH; i++) tape[i] = 0;
    mptr = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cell"}, cell_out, tape[mptr]);
    check({tag, "_zero"}, cell_zero, (tape[mptr] == 0) ? 1 : 0);
    check({tag, "_ptr"}, ptr_out, mptr);
    check({tag, "_err"}, err, merr);
  endtask

  // Counts rising edges until cmd_ready rises; a full sweep takes DEPTH edges.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 4 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, DEPTH);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, cmd_ready, 0);
    check({tag, "_ptr"}, ptr_out, 0);
    check({tag, "_cell"}, cell_out, 0);
    check({tag, "_zero"}, cell_zero, 1);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset(input bit mid_clear);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    if (mid_clear) begin
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
    end
    model_clear_tape();
    merr = 1'b0;
    wait_ready(mid_clear ? "midclr" : "clr");
    check_state("post_rst");
  endtask

  task automatic model_step(input int op, input int data);
    case (op)
      1: tape[mptr] = (tape[mptr] + 1) % MOD;
      2: tape[mptr] = (tape[mptr] + MOD - 1) % MOD;
      5: tape[mptr] = data;
      6: tape[mptr] = (tape[mptr] + data) % MOD;
      3: begin
        if (mptr == DEPTH - 1) begin
`ifdef BF_TAPE_WRAP_EN
          mptr = 0;
`else
          merr = 1'b1;
`endif
        end else mptr++;
      end
      4: begin
        if (mptr == 0) begin
`ifdef BF_TAPE_WRAP_EN
          mptr = DEPTH - 1;
`else
          merr = 1'b1;
`endif
        end else mptr--;
      end
      7: model_clear_tape();
      default: ;
    endcase
  endtask

  // Called just after a rising edge; drives one command and checks the result.
  task automatic issue(input int op, input int data);
    check("issue_rdy", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = DATA_W'(data);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_step(op, data);
    if (op == 3 || op == 4) begin
      check("fetch_busy", cmd_ready, 0);
      @(posedge clk); #1;
      check("fetch_done", cmd_ready, 1);
    end else if (op == 7) begin
      wait_ready("clrall");
    end
    check_state("op");
  endtask

  initial begin
    do_reset(1'b0);

    issue(1, 0); issue(1, 0); issue(1, 0); issue(2, 0);
    check("inc3dec_cell", cell_out, 2);
    check("inc3dec_zero", cell_zero, 0);

    issue(5, 8'hFF); issue(1, 0);
    check("wrap_inc_cell", cell_out, 0);
    check("wrap_inc_zero", cell_zero, 1);
    issue(5, 8'hFE); issue(6, 8'h05);
    check("add_wrap", cell_out, 3);

    issue(5, 7); issue(3, 0); issue(5, 9);
    check("move_r_cell", cell_out, 9);
    check("move_r_ptr", ptr_out, 1);
    issue(4, 0);
    check("move_l_cell", cell_out, 7);
    check("move_l_ptr", ptr_out, 0);

    issue(4, 0);
`ifdef BF_TAPE_WRAP_EN
    check("left0_ptr", ptr_out, DEPTH - 1);
    check("left0_err", err, 0);
`else
    check("left0_ptr", ptr_out, 0);
    check("left0_err", err, 1);
`endif
    issue(7, 0);
`ifndef BF_TAPE_WRAP_EN
    check("err_sticky", err, 1);
`endif

    do_reset(1'b1);

    // Populate low cells, park at ptr 5, clear, then scan the whole tape.
    for (int i = 0; i < 7; i++) begin
      issue(5, $urandom_range(1, MOD - 1));
      issue(3, 0);
    end
    issue(4, 0); issue(4, 0);
    check("park_ptr", ptr_out, 5);
    issue(7, 0);
    check("clrall_ptr", ptr_out, 0);
    for (int i = 0; i < DEPTH - 1; i++) issue(3, 0);
    check("scan_end_ptr", ptr_out, DEPTH - 1);
    issue(3, 0);

    for (int i = 0; i < 600; i++) begin
      int op;
      if ($urandom_range(0, 99) == 0) op = 7;
      else op = $urandom_range(0, 6);
      issue(op, $urandom_range(0, MOD - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
